uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

Peripheral-side transmit engine for the FPGA UART. It consumes the control and TX data register outputs of the UART register bank and serialises bytes onto the UART line (LSB first, 8N1/8E1/8O1, one or two stop bits). It reports its status back to the register bank through the peripheral write port. A one-entry holding buffer lets the CPU queue the next byte while the current frame shifts.

## Interface
Parameters:
- REG_WIDTH, 32, width of register words.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; one clock, reset is synchronous and active-high.
- ctrl_reg_i  input  REG_WIDTH  control register contents: bit0 TX_EN, bit4 PAR_EN, bit5 PAR_ODD, bit6 STOP2.
- tx_reg_i  input  REG_WIDTH  TX data register contents; bits [7:0] used.
- tx_wr_i  input  1  one-cycle strobe: CPU write to the TX data address. The register updates on this same edge.
- tx_o  output  1  serial line, idle high.
- stat_data_o  output  REG_WIDTH  status word; only TX bits are driven, all others 0. bit16 TX_DONE, bit17 TX_BUSY, bit18 TX_BUF_FULL, bit19 TX_OVERRUN.
- stat_wr_en_o  output  1  one-cycle write enable to the status register peripheral port.

## Operation
- tx_wr_i is registered one cycle (wr_q). tx_reg_i[7:0] is captured into the holding buffer when wr_q=1, TX_EN=1 and the buffer is empty.
- If wr_q=1 while the buffer is full, the byte is dropped and TX_OVERRUN is set. TX_OVERRUN stays sticky until TX_EN=0 or reset.
- If wr_q=1 while TX_EN=0, the byte is dropped silently.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE/START.
  - IDLE: tx_o=1. When the buffer is full, move the buffer into the shift register, empty the buffer, and go to START.
  - START: tx_o=0 for 1 bit.
  - DATA: 8 bits, LSB first, bit index 0..7.
  - PARITY: entered only when PAR_EN=1. Drives XOR of the data bits (even parity), inverted when PAR_ODD=1.
  - STOP: tx_o=1 for 1 bit, or 2 bits when STOP2=1. At the end of STOP, load the next byte directly into START if the buffer is full, otherwise go to IDLE.
- Frame configuration (PAR_EN, PAR_ODD, STOP2) is latched on START entry. Changes mid-frame affect only the next frame.
- TX_EN falling mid-frame: the current frame completes, the holding buffer is flushed, and TX_OVERRUN is cleared.
- Status: TX_BUSY = FSM not IDLE. TX_BUF_FULL = buffer occupied. TX_DONE = 1 only in the status word written at the end of a STOP.
- stat_wr_en_o pulses for one cycle when any of TX_BUSY, TX_BUF_FULL or TX_OVERRUN changes, or when a frame ends. The top level ORs stat_data_o with the RX status source.

## Timing
- Reset values: tx_o=1, stat_data_o=0, stat_wr_en_o=0, FSM=IDLE, buffer empty, all counters 0.
- Reset asserted mid-frame: tx_o is 1 the cycle after the reset edge, and the frame is abandoned.
- Latency: tx_wr_i high at edge N (IDLE, buffer empty) → buffer loaded at N+1 → START entered and tx_o=0 from N+2.
- Bit period: the baud counter counts 0..CLKS_PER_BIT-1 and the bit advances on the terminal count. Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length in cycles: CLKS_PER_BIT×(10 + PAR_EN + STOP2).
- Back-to-back frames: with the buffer full at the end of STOP, the next START begins on the following cycle with no idle gap.
- Status write: stat_wr_en_o is asserted in the cycle after the causing event. stat_data_o is held stable until the next write.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state and the PAR_EN/PAR_ODD fields are implemented.
- UART_TX_PARITY_EN undefined: the PARITY state is not built, ctrl bits 4–5 are ignored, and frames are always 8N1/8N2.

## Structure
- uart_pkg holds:
  - register address constants (STAT=0, CTRL=1, TX=2, RX=3);
  - ctrl bit indices (TX_EN, PAR_EN, PAR_ODD, STOP2);
  - status bit indices (TX_DONE, TX_BUSY, TX_BUF_FULL, TX_OVERRUN);
  - FSM state encodings.
- Sub-module uart_baud_gen: counter with CLKS_PER_BIT parameter, sync clear input and one-cycle bit_tick_o output. It will be reused by the RX engine.

## Test plan
All scenarios run with CLKS_PER_BIT=4.
- Reset mid-frame: reset during DATA → tx_o=1 and stat_data_o=0 the next cycle; no further stat_wr_en_o pulses.
- 8N1 frame: TX_EN=1, write 0x55 → tx_o=0 from cycle +2, then 1,0,1,0,1,0,1,0,1 at 4 cycles per bit. Total 40 cycles. TX_DONE is written at the end.
- Parity (macro defined): PAR_EN=1, write 0xA5 → parity bit 0; with PAR_ODD=1 → parity bit 1. Frame is 44 cycles.
- Back-to-back and overrun: write 0x01, then 0x02 during START, then 0x03 during DATA → 0x01 and 0x02 are sent with no idle gap. 0x03 is dropped, TX_OVERRUN=1 and TX_BUF_FULL=1 until 0x02 starts.
- STOP2 and disable: STOP2=1, write 0xFF → stop held 8 cycles. Clearing TX_EN mid-frame completes the frame, flushes the buffer and clears TX_OVERRUN. A write while TX_EN=0 produces no frame.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART register map, ctrl/status bit positions and TX FSM encoding
package uart_pkg;

  localparam logic [1:0] ADDR_STAT = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_TX   = 2'd2;
  localparam logic [1:0] ADDR_RX   = 2'd3;

  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_PAR_EN  = 4;
  localparam int CTRL_PAR_ODD = 5;
  localparam int CTRL_STOP2   = 6;

  localparam int STAT_TX_DONE     = 16;
  localparam int STAT_TX_BUSY     = 17;
  localparam int STAT_TX_BUF_FULL = 18;
  localparam int STAT_TX_OVERRUN  = 19;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter shared by the TX and RX engines
// Counts 0..CLKS_PER_BIT-1 while clr_i is low; bit_tick_o marks the terminal count.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic bit_tick_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term     = (r_cnt == TERM);
  assign bit_tick_o = w_term & ~clr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || w_term) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit engine with one-entry holding buffer and status writeback
// Define UART_TX_PARITY_EN to build the parity bit state (PAR_EN/PAR_ODD); otherwise frames are 8N1/8N2.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int REG_WIDTH    = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [REG_WIDTH-1:0] ctrl_reg_i,
  input  logic [REG_WIDTH-1:0] tx_reg_i,
  input  logic                 tx_wr_i,
  output logic                 tx_o,
  output logic [REG_WIDTH-1:0] stat_data_o,
  output logic                 stat_wr_en_o
);

  tx_state_e r_state;
  tx_state_e w_state_nxt;

  logic       r_wr_q;
  logic [7:0] r_buf;
  logic       r_buf_full;
  logic       r_overrun;
  logic [7:0] r_data;
  logic [2:0] r_bit;
  logic       r_stop2;
`ifdef UART_TX_PARITY_EN
  logic       r_par_en;
  logic       r_par_odd;
`endif

  logic [REG_WIDTH-1:0] r_stat_data;
  logic                 r_stat_wr;

  logic w_tx_en;
  logic w_buf_avail;
  logic w_take;
  logic w_frame_end;
  logic w_tick;
  logic w_tx;
  logic w_capture;
  logic w_buf_full_nxt;
  logic w_overrun_nxt;
  logic w_busy_nxt;
  logic w_baud_clr;
  logic w_stat_evt;
  logic [REG_WIDTH-1:0] w_stat_word;
  logic w_unused;

  assign w_tx_en     = ctrl_reg_i[CTRL_TX_EN];
  assign w_buf_avail = r_buf_full & w_tx_en;
  assign w_capture   = r_wr_q & w_tx_en & ~r_buf_full;
  assign w_baud_clr  = (r_state == TX_IDLE);
  assign w_unused    = ^{ctrl_reg_i, tx_reg_i};

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (w_baud_clr),
    .bit_tick_o(w_tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= TX_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_frame_end = 1'b0;
    w_tx        = 1'b1;
    case (r_state)
      TX_IDLE: begin
        if (w_buf_avail) begin
          w_state_nxt = TX_START;
          w_take      = 1'b1;
        end
      end
      TX_START: begin
        w_tx = 1'b0;
        if (w_tick) w_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        w_tx = r_data[r_bit];
        if (w_tick && r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = r_par_en ? TX_PARITY : TX_STOP;
`else
          w_state_nxt = TX_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        w_tx = (^r_data) ^ r_par_odd;
        if (w_tick) w_state_nxt = TX_STOP;
      end
`endif
      TX_STOP: begin
        // r_bit counts stop bits here; the last one is index 1 only for two-stop frames
        if (w_tick && r_bit == {2'b00, r_stop2}) begin
          w_frame_end = 1'b1;
          if (w_buf_avail) begin
            w_state_nxt = TX_START;
            w_take      = 1'b1;
          end else begin
            w_state_nxt = TX_IDLE;
          end
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    w_buf_full_nxt = r_buf_full;
    if (!w_tx_en) begin
      w_buf_full_nxt = 1'b0;
    end else if (w_take) begin
      w_buf_full_nxt = 1'b0;
    end else if (w_capture) begin
      w_buf_full_nxt = 1'b1;
    end
  end

  assign w_overrun_nxt = w_tx_en & (r_overrun | (r_wr_q & r_buf_full));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_q     <= 1'b0;
      r_buf      <= 8'h00;
      r_buf_full <= 1'b0;
      r_overrun  <= 1'b0;
      r_data     <= 8'h00;
      r_bit      <= 3'd0;
      r_stop2    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
`endif
    end else begin
      r_wr_q     <= tx_wr_i;
      r_buf_full <= w_buf_full_nxt;
      r_overrun  <= w_overrun_nxt;
      if (w_capture) r_buf <= tx_reg_i[7:0];
      // frame format is frozen here so mid-frame ctrl writes only affect the next frame
      if (w_take) begin
        r_data    <= r_buf;
        r_stop2   <= ctrl_reg_i[CTRL_STOP2];
`ifdef UART_TX_PARITY_EN
        r_par_en  <= ctrl_reg_i[CTRL_PAR_EN];
        r_par_odd <= ctrl_reg_i[CTRL_PAR_ODD];
`endif
      end
      if (w_state_nxt != r_state) begin
        r_bit <= 3'd0;
      end else if (w_tick) begin
        r_bit <= r_bit + 3'd1;
      end
    end
  end

  assign w_busy_nxt = (w_state_nxt != TX_IDLE);
  assign w_stat_evt = w_frame_end
                    | (w_busy_nxt != (r_state != TX_IDLE))
                    | (w_buf_full_nxt != r_buf_full)
                    | (w_overrun_nxt != r_overrun);

  always_comb begin
    w_stat_word                   = '0;
    w_stat_word[STAT_TX_DONE]     = w_frame_end;
    w_stat_word[STAT_TX_BUSY]     = w_busy_nxt;
    w_stat_word[STAT_TX_BUF_FULL] = w_buf_full_nxt;
    w_stat_word[STAT_TX_OVERRUN]  = w_overrun_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat_wr   <= 1'b0;
      r_stat_data <= '0;
    end else begin
      r_stat_wr <= w_stat_evt;
      if (w_stat_evt) r_stat_data <= w_stat_word;
    end
  end

  assign tx_o         = w_tx;
  assign stat_data_o  = r_stat_data;
  assign stat_wr_en_o = r_stat_wr;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - scoreboard bench for uart_tx_engine at CLKS_PER_BIT=4
// Frame bits and start cycles come from a timing/frame model; a line monitor pops and compares.
module tb_uart_tx_engine;

  localparam int CPB = 4;
  localparam int RW  = 32;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [RW-1:0] ctrl_reg_i = '0;
  logic [RW-1:0] tx_reg_i = '0;
  logic          tx_wr_i = 1'b0;
  logic          tx_o;
  logic [RW-1:0] stat_data_o;
  logic          stat_wr_en_o;

  uart_tx_engine #(.REG_WIDTH(RW), .CLKS_PER_BIT(CPB)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .ctrl_reg_i  (ctrl_reg_i),
    .tx_reg_i    (tx_reg_i),
    .tx_wr_i     (tx_wr_i),
    .tx_o        (tx_o),
    .stat_data_o (stat_data_o),
    .stat_wr_en_o(stat_wr_en_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          start;
    logic [7:0]  data;
  } frame_t;

  frame_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  int model_end = 0;
  int last_start = 0;
  int n_sent = 0;

  int n_stat_wr = 0;
  int n_done = 0;
  int n_low = 0;
  int n_unstable = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic frame_t build(input logic [7:0] d, input logic pe, input logic po,
                                   input logic s2, input int start);
    frame_t f;
    int n;
    f.bits = '0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
    n = 9;
    if (pe) begin
      f.bits[n] = (^d) ^ po;
      n++;
    end
    f.bits[n] = 1'b1;
    n++;
    if (s2) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.nbits = n;
    f.start = start;
    f.data  = d;
    return f;
  endfunction

  task automatic at(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_raw(input logic [7:0] b);
    tx_reg_i = $urandom();
    tx_reg_i[7:0] = b;
    tx_wr_i = 1'b1;
    @(posedge clk);
    #1;
    tx_wr_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int w;
    int st;
    logic pe;
    frame_t f;
    w  = cyc + 1;
    st = (w + 2 > model_end) ? w + 2 : model_end;
`ifdef UART_TX_PARITY_EN
    pe = ctrl_reg_i[4];
`else
    pe = 1'b0;
`endif
    f = build(b, pe, ctrl_reg_i[5], ctrl_reg_i[6], st);
    exp_q.push_back(f);
    model_end  = st + f.nbits * CPB;
    last_start = st;
    n_sent++;
    wr_raw(b);
  endtask

  task automatic stat_at(input int t, input string name, input logic [31:0] e);
    at(t);
    @(negedge clk);
    check(name, stat_data_o, e);
    @(posedge clk);
    #1;
  endtask

  initial begin : line_monitor
    frame_t e;
    int s;
    int bad;
    int k;
    forever begin
      @(negedge clk);
      if (mon_en && tx_o === 1'b0) begin
        s = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: start seen at cycle %0d, none expected", s);
          k = 0;
          while (tx_o === 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
          end
        end else begin
          e = exp_q.pop_front();
          bad = 0;
          for (int i = 0; i < e.nbits * CPB; i++) begin
            if (i > 0) @(negedge clk);
            if (tx_o !== e.bits[i/CPB]) bad++;
          end
          check($sformatf("frame_start_%02h", e.data), s, e.start);
          check($sformatf("frame_bits_%02h", e.data), bad, 0);
        end
      end
    end
  end

  initial begin : stat_monitor
    logic [31:0] last_word;
    bit prev_rst;
    last_word = '0;
    prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_rst) last_word = '0;
      if (stat_wr_en_o === 1'b1) begin
        n_stat_wr++;
        if (stat_data_o[16]) n_done++;
        last_word = stat_data_o;
      end else if (stat_data_o !== last_word) begin
        n_unstable++;
      end
      if (tx_o === 1'b0) n_low++;
      prev_rst = rst_i;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0;
    int lo0;
    int wr0;
    int d0;
    logic [31:0] c;

    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_tx_o", tx_o, 1);
    check("rst_stat_data", stat_data_o, 0);
    check("rst_stat_wr", stat_wr_en_o, 0);
    @(posedge clk);
    #1;

    // reset while the frame is in DATA
    ctrl_reg_i = 32'h1;
    wr_raw(8'h5A);
    t0 = cyc;
    at(t0 + 10);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    wr0 = n_stat_wr;
    lo0 = n_low;
    @(negedge clk);
    check("rstmid_tx_o", tx_o, 1);
    check("rstmid_stat_data", stat_data_o, 0);
    repeat (30) @(posedge clk);
    #1;
    check("rstmid_no_stat_wr", n_stat_wr - wr0, 0);
    check("rstmid_line_idle", n_low - lo0, 0);

    mon_en = 1'b1;
    n_sent = 0;
    d0 = n_done;

    // 8N1 0x55
    send(8'h55);
    t0 = cyc;
    stat_at(t0 + 10, "8n1_busy_word", 32'h0002_0000);
    at(model_end + 1);
    check("8n1_done_write", n_done - d0, 1);
    check("8n1_final_word", stat_data_o, 32'h0001_0000);

    // parity even then odd (ctrl bits 4-5 ignored when parity is not built)
    ctrl_reg_i = 32'h11;
    send(8'hA5);
    at(model_end + 1);
    ctrl_reg_i = 32'h31;
    send(8'hA5);
    at(model_end + 1);

    // back-to-back and overrun
    ctrl_reg_i = 32'h1;
    send(8'h01);
    t0 = cyc;
    at(t0 + 2);
    send(8'h02);
    at(t0 + 7);
    wr_raw(8'h03);
    stat_at(t0 + 12, "ovr_word", 32'h000E_0000);
    stat_at(t0 + 41, "ovr_before_start", 32'h000E_0000);
    stat_at(t0 + 44, "ovr_after_start", 32'h000B_0000);
    at(t0 + 50);
    ctrl_reg_i = 32'h0;
    stat_at(t0 + 53, "ovr_cleared", 32'h0002_0000);
    at(model_end + 1);
    check("ovr_final_word", stat_data_o, 32'h0001_0000);

    // two stop bits: the following frame must start exactly 44 cycles later
    ctrl_reg_i = 32'h41;
    send(8'hFF);
    t0 = cyc;
    at(t0 + 2);
    send(8'h00);
    at(model_end + 1);

    // disable mid-frame flushes the buffer and clears overrun
    ctrl_reg_i = 32'h1;
    send(8'h11);
    t0 = cyc;
    at(t0 + 3);
    wr_raw(8'h22);
    at(t0 + 6);
    wr_raw(8'h33);
    stat_at(t0 + 10, "dis_pre_word", 32'h000E_0000);
    at(t0 + 12);
    ctrl_reg_i = 32'h0;
    stat_at(t0 + 15, "dis_flush_word", 32'h0002_0000);
    at(model_end + 1);
    lo0 = n_low;
    wr0 = n_stat_wr;
    wr_raw(8'h44);
    repeat (30) @(posedge clk);
    #1;
    check("dis_no_frame", n_low - lo0, 0);
    check("dis_no_stat_wr", n_stat_wr - wr0, 0);

    // randomized bytes, formats and write spacing
    for (int i = 0; i < 12; i++) begin
      at(last_start + 1 + $urandom_range(0, 14));
      c = $urandom();
      c[0] = 1'b1;
      ctrl_reg_i = c;
      send(8'($urandom_range(0, 255)));
    end
    at(model_end + 2);
    check("queue_drained", exp_q.size(), 0);
    check("done_count", n_done - d0, n_sent);
    check("stat_stable", n_unstable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
